// File: rtl/layer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_sched_pkg
// Purpose  : Shared types, default widths and arithmetic helpers for the
//            layer MAC scheduler and its accumulator datapath.
// Contents : state_t        - scheduler FSM state encoding
//            DATA_W_DEF     - default activation/weight/bias width
//            ACC_W_DEF      - default accumulator/output width
//            sext64()       - sign-extend a w-bit value to 64 bits
//            clamp64()      - clamp a 64-bit value to the signed w-bit range
// Options  : none (LAYER_SCHED_SAT_EN is consumed by node_mac_acc)
// Revision : 1.0 - initial release
// ============================================================================
package layer_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Values are carried in a 64-bit container so one helper serves any
  // width; callers pass the zero-padded raw bits and the live width w.
  function automatic logic signed [63:0] sext64(input logic [63:0] v,
                                                input int unsigned w);
    logic [63:0] sh;
    sh = v << (64 - w);
    return $signed(sh) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] clamp64(input logic signed [63:0] v,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/node_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : node_mac_acc
// Purpose  : Shared signed 8x8 multiply with bias-load / accumulate select
//            and the accumulator register for one neuron at a time.
// Ports    : clk, rst      - clock, async active-high reset
//            i_en          - a read result is present this cycle
//            i_load        - the present result is k=0 (load bias + product)
//            i_act, i_wgt  - signed activation and weight
//            i_bias        - signed bias (used when i_load=1)
//            o_acc_next    - accumulator value after this cycle's update
// Options  : LAYER_SCHED_SAT_EN - saturate every update to the ACC_W range;
//            otherwise the accumulator wraps modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module node_mac_acc
  import layer_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_act,
  input  logic [DATA_W-1:0] i_wgt,
  input  logic [DATA_W-1:0] i_bias,
  output logic [ACC_W-1:0]  o_acc_next
);

  logic [ACC_W-1:0]    r_acc;
  logic [2*DATA_W-1:0] w_act_x;
  logic [2*DATA_W-1:0] w_wgt_x;
  logic [2*DATA_W-1:0] w_prod;
  logic signed [63:0]  w_prod64;
  logic signed [63:0]  w_base64;
  logic signed [63:0]  w_sum64;
  logic [ACC_W-1:0]    w_next;

  // Low 2*DATA_W bits of the product of sign-extended operands equal the
  // full signed product, so a plain multiply suffices.
  assign w_act_x = {{DATA_W{i_act[DATA_W-1]}}, i_act};
  assign w_wgt_x = {{DATA_W{i_wgt[DATA_W-1]}}, i_wgt};
  assign w_prod  = w_act_x * w_wgt_x;

  assign w_prod64 = sext64({{(64-2*DATA_W){1'b0}}, w_prod}, 2*DATA_W);
  assign w_base64 = i_load ? sext64({{(64-DATA_W){1'b0}}, i_bias}, DATA_W)
                           : sext64({{(64-ACC_W){1'b0}}, r_acc}, ACC_W);
  assign w_sum64  = w_base64 + w_prod64;

`ifdef LAYER_SCHED_SAT_EN
  logic signed [63:0] w_sat64;
  logic               w_unused_hi;
  assign w_sat64     = clamp64(w_sum64, ACC_W);
  assign w_next      = w_sat64[ACC_W-1:0];
  assign w_unused_hi = ^w_sat64[63:ACC_W];
`else
  logic w_unused_hi;
  assign w_next      = w_sum64[ACC_W-1:0];
  assign w_unused_hi = ^w_sum64[63:ACC_W];
`endif

  assign o_acc_next = w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_mac_scheduler
// Purpose  : Time-multiplexed fully-connected layer controller. One shared
//            MAC evaluates NUM_NODES neurons of NUM_IN inputs each, adds the
//            bias, applies ReLU and emits results over valid/ready.
// Ports    : clk, reset            - clock, async active-high reset
//            start                 - layer request, accepted in IDLE only
//            busy, done            - run status / end-of-run pulse
//            rd_en                 - read strobe to act/weight/bias memories
//            act_addr, w_addr, b_addr - memory addresses (k, node*NUM_IN+k, node)
//            act_data, w_data, b_data - read data, one cycle after rd_en
//            out_valid, out_ready  - result handshake
//            out_idx, out_data     - neuron index and ReLU result
// Options  : LAYER_SCHED_SAT_EN - saturating accumulator (see node_mac_acc)
// Revision : 1.0 - initial release
// ============================================================================
module layer_mac_scheduler
  import layer_sched_pkg::*;
#(
  parameter int NUM_IN    = 15,
  parameter int NUM_NODES = 16,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [$clog2(NUM_IN)-1:0]             act_addr,
  output logic [$clog2(NUM_NODES*NUM_IN)-1:0]   w_addr,
  output logic [$clog2(NUM_NODES)-1:0]          b_addr,
  input  logic [DATA_W-1:0]                     act_data,
  input  logic [DATA_W-1:0]                     w_data,
  input  logic [DATA_W-1:0]                     b_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(NUM_NODES)-1:0]          out_idx,
  output logic [ACC_W-1:0]                      out_data
);

  localparam int AW_ACT = $clog2(NUM_IN);
  localparam int AW_W   = $clog2(NUM_NODES*NUM_IN);
  localparam int AW_B   = $clog2(NUM_NODES);
  localparam logic [AW_ACT-1:0] c_k_last    = AW_ACT'(NUM_IN - 1);
  localparam logic [AW_B-1:0]   c_node_last = AW_B'(NUM_NODES - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [AW_ACT-1:0] r_act_addr;
  logic [AW_W-1:0]   r_w_addr;
  logic [AW_B-1:0]   r_b_addr;   // doubles as the current node index
  logic              r_out_valid;
  logic [AW_B-1:0]   r_out_idx;
  logic [ACC_W-1:0]  r_out_data;
  logic              r_vld_d;    // read data arrives this cycle
  logic              r_k0_d;     // ...and it belongs to k=0
  logic [ACC_W-1:0]  w_acc_next;

  node_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (reset),
    .i_en       (r_vld_d),
    .i_load     (r_k0_d),
    .i_act      (act_data),
    .i_wgt      (w_data),
    .i_bias     (b_data),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_act_addr  <= '0;
      r_w_addr    <= '0;
      r_b_addr    <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_vld_d     <= 1'b0;
      r_k0_d      <= 1'b0;
    end else begin
      r_vld_d <= r_rd_en;
      r_k0_d  <= (r_act_addr == '0);
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_MAC;
            r_busy     <= 1'b1;
            r_rd_en    <= 1'b1;
            r_act_addr <= '0;
            r_w_addr   <= '0;
            r_b_addr   <= '0;
          end
        end
        S_MAC: begin
          if (r_act_addr == c_k_last) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_act_addr <= r_act_addr + AW_ACT'(1);
            r_w_addr   <= r_w_addr + AW_W'(1);
          end
        end
        S_DRAIN: begin
          // The last product lands on this edge, so ReLU uses the
          // accumulator's next value rather than the registered one.
          r_state     <= S_OUT;
          r_out_valid <= 1'b1;
          r_out_idx   <= r_b_addr;
          r_out_data  <= w_acc_next[ACC_W-1] ? '0 : w_acc_next;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_b_addr == c_node_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Weight address runs contiguously across nodes.
              r_state    <= S_MAC;
              r_rd_en    <= 1'b1;
              r_act_addr <= '0;
              r_w_addr   <= r_w_addr + AW_W'(1);
              r_b_addr   <= r_b_addr + AW_B'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign act_addr  = r_act_addr;
  assign w_addr    = r_w_addr;
  assign b_addr    = r_b_addr;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mac_scheduler
// Purpose  : Self-checking bench for layer_mac_scheduler (default params).
//            Honours LAYER_SCHED_SAT_EN when choosing expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_mac_scheduler;

  localparam int NI  = 15;
  localparam int NN  = 16;
  localparam int PER = NI + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, rd_en, out_valid;
  logic [3:0]  act_addr, b_addr, out_idx;
  logic [7:0]  w_addr;
  logic [7:0]  act_data = 8'd0;
  logic [7:0]  w_data = 8'd0;
  logic [7:0]  b_data = 8'd0;
  logic [15:0] out_data;

  logic signed [7:0] act_mem [0:NI-1];
  logic signed [7:0] w_mem   [0:NN*NI-1];
  logic signed [7:0] b_mem   [0:NN-1];

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q [NN];

  typedef struct {
    int a;
    int w;
    int b;
    int exp_wrap;
    int exp_sat;
  } vec_t;

  vec_t vecs [9];

  layer_mac_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .act_addr  (act_addr),
    .w_addr    (w_addr),
    .b_addr    (b_addr),
    .act_data  (act_data),
    .w_data    (w_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Synchronous memories: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      act_data <= act_mem[act_addr];
      w_data   <= w_mem[w_addr];
      b_data   <= b_mem[b_addr];
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fill_uniform(input int a, input int w, input int b);
    for (int k = 0; k < NI; k++) act_mem[k] = 8'(a);
    for (int i = 0; i < NN*NI; i++) w_mem[i] = 8'(w);
    for (int n = 0; n < NN; n++) b_mem[n] = 8'(b);
  endtask

  function automatic int model_node(input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < NI; k++) begin
      int p;
      p = int'(act_mem[k]) * int'(w_mem[n*NI+k]);
      acc = (k == 0) ? int'(b_mem[n]) + p : acc + p;
`ifdef LAYER_SCHED_SAT_EN
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
`else
      acc = int'($signed(16'(acc)));
`endif
    end
    return (acc < 0) ? 0 : acc;
  endfunction

  // One full layer run. stall: cycles of out_ready=0 at node 0's result.
  // pulses: extra start pulses in cycles 3 and 272. aligned: caller has
  // already positioned us at a negedge.
  task automatic run_layer(input string tag, input int stall,
                           input bit pulses, input bit aligned);
    int c, n_out, done_cyc, busy_err, stall_left, exp_cyc;
    if (!aligned) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; n_out = 0; done_cyc = -1; busy_err = 0; stall_left = stall;
    while (c < 400 && done_cyc < 0) begin
      @(negedge clk);
      start     = pulses && (c == 3 || c == 272);
      out_ready = 1'b1;
      if (out_valid && out_idx == 4'd0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        chk({tag, "_hold_data"}, int'(out_data), exp_q[0]);
      end
      if (done) begin
        done_cyc = c;
        if (busy) busy_err++;
      end else if (!busy) begin
        busy_err++;
      end
      if (out_valid && out_ready) begin
        if (n_out < NN) begin
          exp_cyc = n_out*PER + NI + 1 + stall;
          chk({tag, "_idx"},  int'(out_idx),  n_out);
          chk({tag, "_data"}, int'(out_data), exp_q[n_out]);
          chk({tag, "_vcyc"}, c, exp_cyc);
        end
        n_out++;
      end
      c++;
    end
    chk({tag, "_nout"},     n_out,    NN);
    chk({tag, "_done_cyc"}, done_cyc, NN*PER + stall);
    chk({tag, "_busy_err"}, busy_err, 0);
    if (pulses) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_after_done"}, int'(busy), 0);
    end
  endtask

  initial begin
    vecs = '{
      '{2,    3,    -5,  85,    85},
      '{2,    -3,   -5,  0,     0},
      '{127,  127,  0,   0,     32767},
      '{-128, -128, 0,   0,     32767},
      '{-128, 127,  127, 18431, 0},
      '{1,    1,    0,   15,    15},
      '{3,    4,    -100, 80,   80},
      '{-1,   5,    7,   0,     0},
      '{0,    0,    127, 127,   127}
    };

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_done",      int'(done),      0);
    chk("rst_rd_en",     int'(rd_en),     0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_addrs",     int'(act_addr) + int'(w_addr) + int'(b_addr) + int'(out_idx), 0);
    reset = 1'b0;

    // Uniform-data table
    for (int v = 0; v < 9; v++) begin
      fill_uniform(vecs[v].a, vecs[v].w, vecs[v].b);
      for (int n = 0; n < NN; n++) begin
`ifdef LAYER_SCHED_SAT_EN
        exp_q[n] = vecs[v].exp_sat;
`else
        exp_q[n] = vecs[v].exp_wrap;
`endif
      end
      run_layer($sformatf("vec%0d", v), 0, 1'b0, 1'b0);
    end

    // Per-node varied data exercises every address path
    for (int k = 0; k < NI; k++) act_mem[k] = 8'(k - 7);
    for (int i = 0; i < NN*NI; i++) w_mem[i] = 8'((i*7) % 11 - 5);
    for (int n = 0; n < NN; n++) b_mem[n] = 8'(n*8 - 60);
    for (int n = 0; n < NN; n++) exp_q[n] = model_node(n);
    run_layer("varied", 0, 1'b0, 1'b0);

    // Backpressure at node 0
    fill_uniform(2, 3, -5);
    for (int n = 0; n < NN; n++) exp_q[n] = 85;
    run_layer("bp", 4, 1'b0, 1'b0);

    // Start pulses while busy / in DONE, then a start in the IDLE cycle
    run_layer("sbusy", 0, 1'b1, 1'b0);
    run_layer("restart273", 0, 1'b0, 1'b1);

    // Reset in cycle 5 aborts the run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_act_addr", int'(act_addr), 5);
    reset = 1'b1;
    #1;
    chk("abort_busy",      int'(busy),      0);
    chk("abort_rd_en",     int'(rd_en),     0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_act_addr",  int'(act_addr),  0);
    chk("abort_w_addr",    int'(w_addr),    0);
    chk("abort_b_addr",    int'(b_addr),    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("post_abort_idle", int'(out_valid) + int'(busy) + int'(rd_en), 0);
    end
    run_layer("after_abort", 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Time-multiplexed controller for one fully-connected layer. A single shared 8x8 signed MAC evaluates NUM_NODES neurons in sequence, each with NUM_IN inputs, plus bias and ReLU.
- Sequences address generation into external synchronous activation, weight and bias memories. Emits one result per neuron through a valid/ready handshake.
- Replaces per-neuron parallel node instances where area matters more than throughput.

Parameters:
- NUM_IN, 15: inputs per neuron.
- NUM_NODES, 16: neurons in the layer.
- DATA_W, 8: activation, weight and bias width (signed).
- ACC_W, 16: accumulator and output width (signed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to evaluate the layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the DONE cycle (exclusive).
- done  out  1  one-cycle pulse when all neurons have been output.
- rd_en  out  1  read strobe to all three memories; high in MAC cycles.
- act_addr  out  clog2(NUM_IN)  activation index k.
- w_addr  out  clog2(NUM_NODES*NUM_IN)  weight index node*NUM_IN+k.
- b_addr  out  clog2(NUM_NODES)  bias index = current node.
- act_data  in  DATA_W  signed; valid the cycle after rd_en.
- w_data  in  DATA_W  signed; valid the cycle after rd_en.
- b_data  in  DATA_W  signed; valid the cycle after rd_en with k=0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  clog2(NUM_NODES)  neuron index of out_data.
- out_data  out  ACC_W  ReLU result, non-negative.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, rd_en, out_valid = 0; all addresses, out_idx, out_data and the accumulator = 0. Reset asserted mid-run aborts immediately; no partial results are emitted afterwards.
- States: IDLE, MAC, DRAIN, OUT, DONE.
- IDLE:
  - start=1 at an edge sets node=0, k=0 and moves to MAC.
- MAC (NUM_IN cycles):
  - rd_en=1; addresses issued for the current k; k increments each cycle.
  - After k=NUM_IN-1 is issued, go to DRAIN.
- Accumulation pipeline:
  - A registered valid/k_d copy tracks each issued read.
  - On the edge after a read: if k_d==0, acc = sext(b_data) + act_data*w_data; otherwise acc = acc + act_data*w_data.
  - Products are full 16-bit signed, sign-extended to ACC_W.
- DRAIN (1 cycle):
  - rd_en=0; the last product is accumulated.
  - At the end of DRAIN: out_data = acc if acc[ACC_W-1]==0, else 0. out_idx=node, out_valid=1.
- OUT:
  - out_valid held high; out_data and out_idx held stable until out_ready=1.
  - On the handshake edge: out_valid=0.
  - If node==NUM_NODES-1, go to DONE. Otherwise node++, k=0, go to MAC (no idle gap).
- DONE (1 cycle): done=1, busy=0; then IDLE.
- start is ignored in MAC, DRAIN, OUT and DONE. A start held high re-triggers only in IDLE.
- Timing, with out_ready tied high and cycle 0 = first cycle after the start edge:
  - per-node period = NUM_IN+2;
  - node n out_valid is high in cycle n*(NUM_IN+2)+NUM_IN+1;
  - done is high in cycle NUM_NODES*(NUM_IN+2) (272 with defaults).
- Each cycle out_ready is low during OUT delays all later events by one cycle.
- Overflow: without the optional feature, the accumulator wraps modulo 2^ACC_W.

Optional Feature:
- Macro: LAYER_SCHED_SAT_EN.
- Defined: every accumulate, including the bias load, is computed at ACC_W+1 bits. The result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Undefined: two's-complement wrap, no clamp logic.

Decomposition:
- Package layer_sched_pkg:
  - state enum typedef;
  - default DATA_W and ACC_W constants;
  - saturate/sign-extend helper functions.
- One sub-module, node_mac_acc:
  - signed multiply, bias-load/accumulate select, optional saturation;
  - holds the accumulator register.
- Scheduler FSM, counters and handshake stay in the top.

Test Plan:
- Basic run (defaults): act=2, w=3, bias=-5 for all nodes; out_ready=1 → each out_data=85.
  - out_idx 0..15 appear in cycles 16, 33, ..., 271; done in cycle 272; busy high in cycles 0..271.
- Negative sum: act=2, w=-3, bias=-5 → every out_data=0, since the sum is -95.
- Backpressure: out_ready=0 for 4 cycles at node 0 OUT → out_valid stays high and out_data=85 holds; done moves to cycle 276.
- Overflow: act=127, w=127, bias=0:
  - macro undefined → sum wraps to -20209 → out_data=0;
  - macro defined → out_data=32767.
- Reset and restart: assert reset in cycle 5 → busy, rd_en, out_valid and addresses are 0 asynchronously. Start after release → full run from node 0 with correct results.
- Start while busy: pulse start in cycles 3 and 272 → both ignored. Start in cycle 273 (IDLE) → new run begins.
